// File: rtl/tc_pkg.sv
// Shared tensor-core definitions: array geometry, element width and push FSM states.
package tc_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int ARRAY_DIM   = 4;
    localparam int NUM_THREADS = 8;
    localparam int FEED_CYCLES = 2 * ARRAY_DIM - 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } push_state_t;
endpackage

// File: rtl/push_skew_buffer.sv
// Operand buffer for A/B, filled one register-file beat at a time, plus the
// diagonally skewed left/top edge feeds for the systolic array.
module push_skew_buffer import tc_pkg::*; #(
    parameter int DW = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [1:0]                   i_beat,
    input  logic [NUM_THREADS*DW-1:0]    i_data,
    input  logic                         i_feed_en,
    input  logic [2:0]                   i_feed_idx,
    output logic [ARRAY_DIM*DW-1:0]      o_a,
    output logic [ARRAY_DIM*DW-1:0]      o_b
);
    logic [ARRAY_DIM-1:0][ARRAY_DIM-1:0][DW-1:0] r_a, r_b;
    logic [ARRAY_DIM-1:0][DW-1:0]                w_a_nxt, w_b_nxt;

    // beat[1] picks A/B, beat[0] picks the row pair; thread t lands at row t/4, col t%4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_wr_en) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (i_beat[1])
                    r_b[{i_beat[0], 1'(t / ARRAY_DIM)}][2'(t % ARRAY_DIM)] <= i_data[t*DW +: DW];
                else
                    r_a[{i_beat[0], 1'(t / ARRAY_DIM)}][2'(t % ARRAY_DIM)] <= i_data[t*DW +: DW];
            end
        end
    end

    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
        logic [2:0] w_d;
        logic       w_hit;
        assign w_d        = i_feed_idx - 3'(i);
        assign w_hit      = i_feed_en && (i_feed_idx >= 3'(i)) && (w_d < 3'(ARRAY_DIM));
        assign w_a_nxt[i] = w_hit ? r_a[i][w_d[1:0]] : '0;
        assign w_b_nxt[i] = w_hit ? r_b[w_d[1:0]][i] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_a <= '0;
            o_b <= '0;
        end else begin
            o_a <= w_a_nxt;
            o_b <= w_b_nxt;
        end
    end
endmodule

// File: rtl/push_unit.sv
// Push unit: gathers 4x4 A/B over four beats, then streams them skewed into the
// systolic array. Optional feature macro: PUSH_UNIT_ACCUMULATE_EN (suppresses array_clear).
module push_unit #(
    parameter int DATA_WIDTH   = tc_pkg::DATA_WIDTH,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start_push,
`ifdef PUSH_UNIT_ACCUMULATE_EN
    input  logic                                        accumulate,
`endif
    input  logic [tc_pkg::NUM_THREADS*DATA_WIDTH-1:0]   reg_read_data,
    output logic                                        operand_rd_en,
    output logic [1:0]                                  beat_idx,
    output logic [tc_pkg::ARRAY_DIM*DATA_WIDTH-1:0]     a_in,
    output logic [tc_pkg::ARRAY_DIM*DATA_WIDTH-1:0]     b_in,
    output logic                                        feed_valid,
    output logic                                        array_clear,
    output logic                                        busy,
    output logic                                        matmul_done
);
    import tc_pkg::*;

    localparam logic [2:0] LOAD_LAST  = 3'(ARRAY_DIM - 1);
    localparam logic [2:0] FEED_LAST  = 3'(FEED_CYCLES - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    push_state_t r_state, w_state_nxt;
    logic [2:0]  r_phase, w_phase_nxt;
    logic        w_start_ok, w_accum;
    logic        w_rd_en_nxt, w_feed_nxt, w_clear_nxt, w_busy_nxt, w_done_nxt;
    logic [1:0]  w_beat_nxt;

    assign w_start_ok = start_push && (r_state == IDLE || r_state == DONE);

`ifdef PUSH_UNIT_ACCUMULATE_EN
    logic r_accum;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_accum <= 1'b0;
        else if (w_start_ok) r_accum <= accumulate;
    end
    assign w_accum = r_accum;
`else
    assign w_accum = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 3'd1;
        case (r_state)
            IDLE, DONE: begin
                w_phase_nxt = '0;
                if (w_start_ok) w_state_nxt = LOAD;
            end
            LOAD: if (r_phase == LOAD_LAST) begin
                w_state_nxt = CLEAR;
                w_phase_nxt = '0;
            end
            CLEAR: begin
                w_state_nxt = FEED;
                w_phase_nxt = '0;
            end
            FEED: if (r_phase == FEED_LAST) begin
                w_state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                w_phase_nxt = '0;
            end
            DRAIN: if (r_phase == DRAIN_LAST) begin
                w_state_nxt = DONE;
                w_phase_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered with no lag
    always_comb begin
        w_rd_en_nxt = (w_state_nxt == LOAD);
        w_beat_nxt  = w_rd_en_nxt ? w_phase_nxt[1:0] : 2'd0;
        w_feed_nxt  = (w_state_nxt == FEED);
        w_clear_nxt = (w_state_nxt == CLEAR) && !w_accum;
        w_busy_nxt  = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done_nxt  = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operand_rd_en <= 1'b0;
            beat_idx      <= '0;
            feed_valid    <= 1'b0;
            array_clear   <= 1'b0;
            busy          <= 1'b0;
            matmul_done   <= 1'b0;
        end else begin
            operand_rd_en <= w_rd_en_nxt;
            beat_idx      <= w_beat_nxt;
            feed_valid    <= w_feed_nxt;
            array_clear   <= w_clear_nxt;
            busy          <= w_busy_nxt;
            matmul_done   <= w_done_nxt;
        end
    end

    push_skew_buffer #(.DW(DATA_WIDTH)) u_skew (
        .clk        (clk),
        .rst_n      (reset),
        .i_wr_en    (operand_rd_en),
        .i_beat     (beat_idx),
        .i_data     (reg_read_data),
        .i_feed_en  (w_feed_nxt),
        .i_feed_idx (w_phase_nxt),
        .o_a        (a_in),
        .o_b        (b_in)
    );
endmodule

// File: tb/tb_push_unit.sv
// Directed bench for push_unit: per-cycle timing expectations relative to the
// start edge, and a scoreboard of expected skewed feeds popped on each feed cycle.
module tb_push_unit;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_push;
`ifdef PUSH_UNIT_ACCUMULATE_EN
    logic            accumulate;
`endif
    logic [8*DW-1:0] reg_read_data;
    logic            operand_rd_en;
    logic [1:0]      beat_idx;
    logic [4*DW-1:0] a_in, b_in;
    logic            feed_valid, array_clear, busy, matmul_done;

    logic [DW-1:0]   mA [4][4];
    logic [DW-1:0]   mB [4][4];
    logic [63:0]     q_a[$];
    logic [63:0]     q_b[$];
    int              n_tests = 0;
    int              n_fail  = 0;

    always #5 clk = ~clk;

    push_unit #(.DATA_WIDTH(DW), .DRAIN_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_push    (start_push),
`ifdef PUSH_UNIT_ACCUMULATE_EN
        .accumulate    (accumulate),
`endif
        .reg_read_data (reg_read_data),
        .operand_rd_en (operand_rd_en),
        .beat_idx      (beat_idx),
        .a_in          (a_in),
        .b_in          (b_in),
        .feed_valid    (feed_valid),
        .array_clear   (array_clear),
        .busy          (busy),
        .matmul_done   (matmul_done)
    );

    // Thread register files: beats 0/1 serve A row pairs, beats 2/3 serve B row pairs
    always_comb begin
        reg_read_data = '0;
        for (int t = 0; t < 8; t++) begin
            if (beat_idx[1]) reg_read_data[t*DW +: DW] = mB[2*beat_idx[0] + t/4][t%4];
            else             reg_read_data[t*DW +: DW] = mA[2*beat_idx[0] + t/4][t%4];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 64'({operand_rd_en, beat_idx, feed_valid, array_clear, busy, matmul_done}), 64'd0);
        chk({tag, "_a"}, a_in, 64'd0);
        chk({tag, "_b"}, b_in, 64'd0);
    endtask

    task automatic set_basic();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                mA[i][j] = 16'(4*i + j + 1);
                mB[i][j] = (i == j) ? 16'd1 : 16'd0;
            end
    endtask

    task automatic set_rand();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                mA[i][j] = 16'($urandom_range(1, 16'hFFFF));
                mB[i][j] = 16'($urandom_range(1, 16'hFFFF));
            end
    endtask

    // a_in[i] = A[i][t-i], b_in[j] = B[t-j][j] inside the 4-wide diagonal window
    task automatic push_expect();
        logic [63:0] ea, eb;
        int d;
        for (int t = 0; t < 7; t++) begin
            ea = '0;
            eb = '0;
            for (int i = 0; i < 4; i++) begin
                d = t - i;
                if (d >= 0 && d < 4) begin
                    ea[i*DW +: DW] = mA[i][d];
                    eb[i*DW +: DW] = mB[d][i];
                end
            end
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
    endtask

    // c = cycles since the edge that sampled start_push
    task automatic check_cycle(input int c, input bit acc);
        logic        e_rd, e_clr, e_feed, e_busy, e_done;
        logic [1:0]  e_beat;
        logic [63:0] ea, eb;
        e_rd   = (c >= 1 && c <= 4);
        e_beat = e_rd ? 2'(c - 1) : 2'd0;
        e_clr  = (c == 5) && !acc;
        e_feed = (c >= 6 && c <= 12);
        e_busy = (c >= 1 && c <= 14);
        e_done = (c >= 15);
        chk($sformatf("rd_en@%0d", c), 64'(operand_rd_en), 64'(e_rd));
        chk($sformatf("beat@%0d", c), 64'(beat_idx), 64'(e_beat));
        chk($sformatf("clear@%0d", c), 64'(array_clear), 64'(e_clr));
        chk($sformatf("feed_valid@%0d", c), 64'(feed_valid), 64'(e_feed));
        chk($sformatf("busy@%0d", c), 64'(busy), 64'(e_busy));
        chk($sformatf("done@%0d", c), 64'(matmul_done), 64'(e_done));
        if (e_feed) begin
            chk($sformatf("sb_avail@%0d", c), 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                chk($sformatf("a_in@%0d", c), a_in, ea);
                chk($sformatf("b_in@%0d", c), b_in, eb);
            end
        end else begin
            chk($sformatf("a_idle@%0d", c), a_in, 64'd0);
            chk($sformatf("b_idle@%0d", c), b_in, 64'd0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start_push = 1'b0;
`ifdef PUSH_UNIT_ACCUMULATE_EN
        accumulate = 1'b0;
`endif
        set_basic();
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        reset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_zero("idle");
        end

        // Basic load/feed with A=4i+j+1, B=I, plus fixed skew-edge values
        push_expect();
        start_push = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start_push = 1'b0;
            check_cycle(c, 1'b0);
            if (c == 6) begin
                chk("edge_t0_a", a_in, 64'h0000_0000_0000_0001);
                chk("edge_t0_b", b_in, 64'h0000_0000_0000_0001);
            end
            if (c == 9)  chk("diag_t3_a", a_in, 64'h000D_000A_0007_0004);
            if (c == 12) begin
                chk("edge_t6_a", a_in, 64'h0010_0000_0000_0000);
                chk("edge_t6_b", b_in, 64'h0001_0000_0000_0000);
            end
        end

        // start_push during FEED is ignored
        set_rand();
        push_expect();
        start_push = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start_push = (c == 8);
            check_cycle(c, 1'b0);
        end

        // Back-to-back: restart in the first DONE cycle
        set_rand();
        push_expect();
        start_push = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start_push = 1'b0;
            check_cycle(c, 1'b0);
        end
        set_rand();
        push_expect();
        start_push = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start_push = 1'b0;
            check_cycle(c, 1'b0);
        end

        // Reset mid-FEED aborts at once; the next push runs normally
        set_rand();
        push_expect();
        start_push = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_push = 1'b0;
            check_cycle(c, 1'b0);
        end
        #1 reset = 1'b0;
        #1 check_zero("rst_async");
        q_a.delete();
        q_b.delete();
        repeat (2) begin
            @(negedge clk);
            check_zero("rst_mid");
        end
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check_zero("post_rst");
        end
        set_rand();
        push_expect();
        start_push = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start_push = 1'b0;
            check_cycle(c, 1'b0);
        end

`ifdef PUSH_UNIT_ACCUMULATE_EN
        // Accumulate: CLEAR cycle still taken but array_clear stays low
        set_rand();
        push_expect();
        start_push = 1'b1;
        accumulate = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start_push = 1'b0;
            accumulate = 1'b0;
            check_cycle(c, 1'b1);
        end
`endif

        chk("sb_drained", 64'(q_a.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/push_unit.md
# push_unit

Push Unit for the tensor-core compute unit. On a push instruction it gathers operand matrices A and B (4×4 each) from the 8 thread register files over four beats and buffers them. It then streams A and B into the 4×4 output-stationary systolic array with diagonal skew. It raises `matmul_done` when the last product has settled, so the Pull Unit can drain results.

## Interface
Parameters:
- `DATA_WIDTH`, 16, element width.
- `DRAIN_CYCLES`, 2, cycles after the last feed before results are final.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_push`  in  1  one-cycle pulse from the scheduler (global instruction).
- `reg_read_data`  in  8*DATA_WIDTH  thread t in bits [t*DW +: DW]; valid combinationally for the current `beat_idx`.
- `operand_rd_en`  out  1  high while loading beats.
- `beat_idx`  out  2  beat selector for the thread register files.
- `a_in`  out  4*DATA_WIDTH  left-edge feeds, row i in [i*DW +: DW].
- `b_in`  out  4*DATA_WIDTH  top-edge feeds, column j in [j*DW +: DW].
- `feed_valid`  out  1  high on every feed cycle.
- `array_clear`  out  1  one-cycle accumulator clear to the array.
- `busy`  out  1  high in any state other than IDLE and DONE.
- `matmul_done`  out  1  level; high in DONE.

## Operation
- FSM states: IDLE, LOAD, CLEAR, FEED, DRAIN, DONE.
- IDLE/DONE + `start_push`: go to LOAD and clear the `matmul_done` level.
- `start_push` in any other state is ignored.
- LOAD runs 4 cycles with beat 0..3. Each cycle, all 8 thread values are captured into the operand buffer:
  - beat 0: thread t gives A[t/4][t%4], i.e. rows 0–1.
  - beat 1: A rows 2–3, thread t gives A[2+t/4][t%4].
  - beat 2: B rows 0–1, same layout.
  - beat 3: B rows 2–3, same layout.
- CLEAR lasts 1 cycle and pulses `array_clear`.
- FEED runs 7 cycles, t = 0..6:
  - `a_in[i]` = A[i][t−i] when 0 ≤ t−i ≤ 3, else 0.
  - `b_in[j]` = B[t−j][j] when 0 ≤ t−j ≤ 3, else 0.
- DRAIN lasts `DRAIN_CYCLES` cycles with feeds at 0. If `DRAIN_CYCLES` is 0, go straight from FEED to DONE.
- DONE holds `matmul_done` high until the next `start_push`.
- No arithmetic is done here. Data passes through unchanged; the only counters are the phase counter (3 bits) and the beat index.

## Timing
- All outputs are registered.
- Reset (async, low) forces IDLE. All outputs reset to 0 and the operand buffer is cleared. Reset mid-operation aborts the operation and no `matmul_done` is raised.
- Let `start_push` be sampled at edge k. Then:
  - `operand_rd_en` is high during cycles k+1..k+4, with `beat_idx` = 0,1,2,3.
  - Data is captured at the end of each of those cycles.
  - `array_clear` is high during cycle k+5.
  - `feed_valid` is high during cycles k+6..k+12.
  - DRAIN covers k+13..k+12+`DRAIN_CYCLES`.
  - `matmul_done` rises at cycle k+13+`DRAIN_CYCLES`, which is k+15 by default.
- `busy` is high from k+1 until `matmul_done` rises.
- `start_push` in the same cycle `matmul_done` rises is honoured, because the FSM is already in DONE.

## Configuration
- `PUSH_UNIT_ACCUMULATE_EN` defined:
  - Adds input port `accumulate` (1 bit), sampled together with `start_push`.
  - If it was high, CLEAR still occupies its cycle but `array_clear` stays 0, so the array computes C += A·B.
  - Latency is unchanged.
- Undefined: no port, and `array_clear` always pulses.

## Structure
- Shared package `tc_pkg`:
  - `DATA_WIDTH`, `ARRAY_DIM` = 4, `NUM_THREADS` = 8.
  - `push_state_t` enum.
  - `FEED_CYCLES` = 2*ARRAY_DIM−1.
- Sub-module `push_skew_buffer`:
  - Holds the 32-element operand buffer, written by beat.
  - Produces the skewed `a_in`/`b_in` from the feed index.
- `push_unit` keeps only the FSM, counters and handshake.

## Test plan
- Reset and idle:
  - Hold `reset` low, then release.
  - All outputs must be 0, `busy` 0 and `matmul_done` 0 for 10 idle cycles.
- Basic load and feed:
  - Load A[i][j]=4i+j+1 and B = identity, pulse `start_push` at edge k.
  - `beat_idx` must be 0..3 at k+1..k+4.
  - At t=3 the feeds must be `a_in` = {A00=… wait, row 0 gives A[0][3]=4, row 1 gives A[1][2]=7, row 2 gives A[2][1]=10, row 3 gives A[3][0]=13}.
  - `matmul_done` must rise at k+15.
- Skew edges:
  - At FEED t=0, only `a_in[0]` and `b_in[0]` are nonzero.
  - At t=6, only `a_in[3]` = A[3][3] and `b_in[3]` = B[3][3] are nonzero.
- Ignored start:
  - Pulse `start_push` during FEED.
  - The sequence must be unchanged, with `matmul_done` still at k+15.
- Back-to-back:
  - Pulse `start_push` in the first DONE cycle.
  - `matmul_done` must fall next cycle and the new LOAD must begin with `beat_idx` 0.
- Reset mid-FEED:
  - Assert `reset` at k+8.
  - Outputs must go to 0 immediately, `matmul_done` must never assert, and the next `start_push` must run normally.
  - With `PUSH_UNIT_ACCUMULATE_EN` defined and `accumulate`=1, `array_clear` must stay 0 at k+5.
